fir_sample_feeder: RTL and testbench

FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

---
 rtl/fir_sample_feeder.sv | 125 ++++++++++++
 tb/tb_fir_sample_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
//   Buffers upstream samples in a small FIFO and plays them out to a
//   serial FIR at one sample per frame of FRAME clocks. Playout starts
//   once PRIME entries are buffered. After that, one entry is popped at
//   every frame boundary (frame_cnt FRAME-1 -> 0). A boundary that finds
//   the FIFO empty is counted as an underflow.
//
//   Build option: FEEDER_UNDERFLOW_HOLD_EN
//     defined   - an underflow frame holds the previous x_out
//     undefined - an underflow frame drives x_out = 0
//
//   Ports
//     clk, rst       clock; asynchronous active-high reset
//     en             synchronous enable; low flushes the FIFO and idles
//     s_data/s_valid upstream sample and its valid
//     s_ready        high when a sample can be accepted (en and not full)
//     x_out          signed sample to the FIR, held for a whole frame
//     x_stb          first cycle of a frame carrying a newly popped sample
//     frame_cnt      free-running frame phase
//     fill           FIFO occupancy
//     underflow_cnt  empty frames seen while running, saturating at 255
module fir_sample_feeder #(
  parameter int DW    = 12,
  parameter int FRAME = 8,
  parameter int DEPTH = 8,
  parameter int PRIME = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DW-1:0]              s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic signed [DW-1:0]       x_out,
  output logic                       x_stb,
  output logic [$clog2(FRAME)-1:0]   frame_cnt,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [7:0]                 underflow_cnt
);

  localparam int FW = $clog2(FRAME);
  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill_nxt;
  logic          boundary;
  logic          push;
  logic          pop;
  logic          underflow;

  assign boundary  = (frame_cnt == FW'(FRAME - 1));
  // rst gates s_ready so that nothing is acknowledged while in reset
  assign s_ready   = en && !rst && (fill < (AW + 1)'(DEPTH));
  assign push      = s_valid && s_ready;
  // The pop decision uses pre-edge fill, so a sample pushed on the
  // same boundary edge into an empty FIFO is not popped until the next boundary.
  assign pop       = en && (state == RUN) && boundary && (fill != '0);
  assign underflow = en && (state == RUN) && boundary && (fill == '0);

  always_comb begin
    fill_nxt = fill;
    if (push && !pop)
      fill_nxt = fill + (AW + 1)'(1);
    else if (pop && !push)
      fill_nxt = fill - (AW + 1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt <= '0;
    else
      frame_cnt <= frame_cnt + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      fill          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      x_out         <= '0;
      x_stb         <= 1'b0;
      underflow_cnt <= '0;
    end else if (!en) begin
      state  <= IDLE;
      fill   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      x_out  <= '0;
      x_stb  <= 1'b0;
    end else begin
      fill  <= fill_nxt;
      x_stb <= pop;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if ((state == IDLE) && (fill_nxt >= (AW + 1)'(PRIME)))
        state <= RUN;
      if (pop)
        x_out <= $signed(mem[rd_ptr]);
      else if (underflow) begin
`ifdef FEEDER_UNDERFLOW_HOLD_EN
        x_out <= x_out;
`else
        x_out <= '0;
`endif
      end
      if (underflow && (underflow_cnt != '1))
        underflow_cnt <= underflow_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Testbench for fir_sample_feeder (DW=12, FRAME=8, DEPTH=8, PRIME=4).
// A table of phases covers priming, playout and underflow. Hand-written
// sequences cover the remaining cases: boundary push, enable drop, reset
// mid-frame, full FIFO and counter saturation. Every accepted sample is
// queued, and the queue is checked against x_out on each x_stb.
module tb_fir_sample_feeder;
  localparam int DW    = 12;
  localparam int FRAME = 8;
  localparam int DEPTH = 8;
  localparam int PRIME = 4;
`ifdef FEEDER_UNDERFLOW_HOLD_EN
  localparam int HOLD = 1;
`else
  localparam int HOLD = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [DW-1:0]        s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] x_out;
  logic                 x_stb;
  logic [2:0]           frame_cnt;
  logic [3:0]           fill;
  logic [7:0]           underflow_cnt;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [DW-1:0] sbq[$];

  typedef struct {
    logic          en;
    logic          valid;
    logic [DW-1:0] data;
    int            ncyc;
    int            fc;
    int            fill;
    int            stb;
    int            x;
    int            rdy;
    int            uf;
  } vec_t;

  vec_t tv[11];

  fir_sample_feeder #(.DW(DW), .FRAME(FRAME), .DEPTH(DEPTH), .PRIME(PRIME)) dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .x_out(x_out), .x_stb(x_stb), .frame_cnt(frame_cnt),
    .fill(fill), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Upstream source: hold the sample until it is accepted (bounded wait).
  task automatic send(input logic [DW-1:0] d);
    int unsigned n = 0;
    s_valid = 1'b1;
    s_data  = d;
    #1;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("send_accept_%0d", d), 32'(s_ready), 1);
    if (s_ready === 1'b1) sbq.push_back(d);
    @(negedge clk);
  endtask

  // Scoreboard: each strobe must carry the oldest accepted sample, at phase 0.
  always @(negedge clk) begin : mon
    logic [DW-1:0] e;
    if (rst === 1'b0 && x_stb === 1'b1) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected_stb: got x_out=%0d, expected no strobe", x_out);
      end else begin
        e = sbq.pop_front();
        chk("sb_x_out", 32'(x_out), 32'(e));
        chk("sb_stb_phase", 32'(frame_cnt), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int hv;
    hv = HOLD ? 400 : 0;
    //         en    valid data     n  fc fill stb x    rdy uf
    tv[0]  = '{1'b1, 1'b1, 12'd100, 1, 1, 1,   0,  0,   1,  0};
    tv[1]  = '{1'b1, 1'b1, 12'd200, 1, 2, 2,   0,  0,   1,  0};
    tv[2]  = '{1'b1, 1'b1, 12'd300, 1, 3, 3,   0,  0,   1,  0};
    tv[3]  = '{1'b1, 1'b1, 12'd400, 1, 4, 4,   0,  0,   1,  0};
    tv[4]  = '{1'b1, 1'b0, 12'd0,   4, 0, 3,   1,  100, 1,  0};
    tv[5]  = '{1'b1, 1'b0, 12'd0,   1, 1, 3,   0,  100, 1,  0};
    tv[6]  = '{1'b1, 1'b0, 12'd0,   7, 0, 2,   1,  200, 1,  0};
    tv[7]  = '{1'b1, 1'b0, 12'd0,   8, 0, 1,   1,  300, 1,  0};
    tv[8]  = '{1'b1, 1'b0, 12'd0,   8, 0, 0,   1,  400, 1,  0};
    tv[9]  = '{1'b1, 1'b0, 12'd0,   8, 0, 0,   0,  hv,  1,  1};
    tv[10] = '{1'b1, 1'b0, 12'd0,   8, 0, 0,   0,  hv,  1,  2};

    rst = 1'b1; en = 1'b1; s_valid = 1'b0; s_data = '0;
    #12;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_fc", 32'(frame_cnt), 0);
    chk("rst_x_out", 32'(x_out), 0);
    chk("rst_x_stb", 32'(x_stb), 0);
    chk("rst_uf", 32'(underflow_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Priming, playout of 100..400 and two underflow frames
    for (int i = 0; i < 11; i++) begin
      en      = tv[i].en;
      s_valid = tv[i].valid;
      s_data  = tv[i].data;
      if (tv[i].valid) sbq.push_back(tv[i].data);
      repeat (tv[i].ncyc) @(negedge clk);
      chk($sformatf("v%0d_fc", i), 32'(frame_cnt), 32'(tv[i].fc));
      chk($sformatf("v%0d_fill", i), 32'(fill), 32'(tv[i].fill));
      chk($sformatf("v%0d_stb", i), 32'(x_stb), 32'(tv[i].stb));
      chk($sformatf("v%0d_x", i), 32'(x_out), 32'(tv[i].x));
      chk($sformatf("v%0d_rdy", i), 32'(s_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_uf", i), 32'(underflow_cnt), 32'(tv[i].uf));
    end
    s_valid = 1'b0;

    // Push onto an empty FIFO exactly at a boundary: underflow, popped next boundary
    repeat (7) @(negedge clk);
    chk("bpush_fc_pre", 32'(frame_cnt), 7);
    s_valid = 1'b1; s_data = 12'd55; sbq.push_back(12'd55);
    @(negedge clk);
    s_valid = 1'b0;
    chk("bpush_fc", 32'(frame_cnt), 0);
    chk("bpush_fill", 32'(fill), 1);
    chk("bpush_stb", 32'(x_stb), 0);
    chk("bpush_uf", 32'(underflow_cnt), 3);
    chk("bpush_x", 32'(x_out), 32'(hv));
    repeat (8) @(negedge clk);
    chk("bpop_fill", 32'(fill), 0);
    chk("bpop_stb", 32'(x_stb), 1);
    chk("bpop_x", 32'(x_out), 55);
    chk("bpop_uf", 32'(underflow_cnt), 3);

    // Drop en for one cycle with three samples buffered (these are discarded)
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = DW'(k + 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("flush_fill_pre", 32'(fill), 3);
    en = 1'b0;
    #1;
    chk("flush_s_ready", 32'(s_ready), 0);
    @(negedge clk);
    chk("flush_fill", 32'(fill), 0);
    chk("flush_x", 32'(x_out), 0);
    chk("flush_stb", 32'(x_stb), 0);
    chk("flush_uf", 32'(underflow_cnt), 3);
    chk("flush_fc", 32'(frame_cnt), 4);
    en = 1'b1;
    // One sample is below PRIME: still idle across a boundary, no underflow
    s_valid = 1'b1; s_data = 12'd77; sbq.push_back(12'd77);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_fc", 32'(frame_cnt), 5);
    chk("idle_fill", 32'(fill), 1);
    chk("idle_x", 32'(x_out), 0);
    chk("idle_uf", 32'(underflow_cnt), 3);
    s_valid = 1'b1; s_data = 12'd88;  sbq.push_back(12'd88);  @(negedge clk);
    s_data = 12'd99;  sbq.push_back(12'd99);  @(negedge clk);
    s_data = 12'd111; sbq.push_back(12'd111); @(negedge clk);
    s_valid = 1'b0;
    chk("reprime_fill", 32'(fill), 4);
    chk("reprime_stb", 32'(x_stb), 0);
    repeat (33) @(negedge clk);
    chk("drain_fill", 32'(fill), 0);
    chk("drain_x", 32'(x_out), 111);
    chk("drain_uf", 32'(underflow_cnt), 3);
    chk("drain_fc", 32'(frame_cnt), 1);
    chk("drain_sbq", 32'(sbq.size()), 0);

    // Reset asserted mid-frame discards buffered samples
    s_valid = 1'b1; s_data = 12'd5;
    @(negedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk("mrst_fill_pre", 32'(fill), 2);
    #2 rst = 1'b1;
    #1;
    chk("mrst_fill", 32'(fill), 0);
    chk("mrst_fc", 32'(frame_cnt), 0);
    chk("mrst_uf", 32'(underflow_cnt), 0);
    chk("mrst_s_ready", 32'(s_ready), 0);
    chk("mrst_x", 32'(x_out), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_fc_rel", 32'(frame_cnt), 0);

    // Continuous pushes from empty until the FIFO is full
    repeat (4) @(negedge clk);
    chk("full_fc_start", 32'(frame_cnt), 4);
    for (int v = 1; v <= 8; v++) send(DW'(v));
    chk("full_fill", 32'(fill), 8);
    chk("full_s_ready", 32'(s_ready), 0);
    chk("full_fc", 32'(frame_cnt), 4);
    send(12'd9);
    chk("ninth_fc", 32'(frame_cnt), 1);
    chk("ninth_fill", 32'(fill), 8);
    send(12'd10);
    s_valid = 1'b0;
    repeat (100) @(negedge clk);
    chk("full_drain_fill", 32'(fill), 0);
    chk("full_drain_fc", 32'(frame_cnt), 5);
    chk("full_drain_sbq", 32'(sbq.size()), 0);

    // Long run of empty frames saturates the underflow counter
    repeat (300 * FRAME) @(negedge clk);
    chk("uf_saturate", 32'(underflow_cnt), 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
